// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the clock/reset sequencer.
package clk_rst_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_FILTER    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  // Width needed to count 0..limit-1, never less than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit; output resets to 0.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/clk_rst_sequencer.sv
// Turns PLL LOCKED into staggered synchronous resets with lock filtering,
// minimum assert time, software reset and a saturating lock-loss counter.
//
// state      | meaning
// WAIT_LOCK  | all resets asserted, waiting for synchronised lock
// FILTER     | lock must stay high LOCK_FILTER cycles
// RELEASE    | channels released one per RELEASE_GAP cycles
// RUN        | all channels out of reset
// HOLD       | all resets re-asserted for MIN_ASSERT cycles
module clk_rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int RELEASE_GAP = 8,
  parameter int MIN_ASSERT  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_locked,
  input  logic             i_sw_rst,
  output logic [N_CH-1:0]  o_rst,
  output logic             o_all_released,
  output logic [ST_W-1:0]  o_state,
  output logic [CNT_W-1:0] o_loss_cnt
);

  localparam int FILT_W = cnt_width(LOCK_FILTER);
  localparam int GAP_W  = cnt_width(RELEASE_GAP);
  localparam int HOLD_W = cnt_width(MIN_ASSERT);
  localparam int IDX_W  = cnt_width(N_CH);

  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILTER - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(RELEASE_GAP - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_ASSERT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_CH - 1);

  logic w_locked_s;

  state_e             r_state,    w_state_nxt;
  logic [FILT_W-1:0]  r_filt_cnt, w_filt_nxt;
  logic [GAP_W-1:0]   r_gap_cnt,  w_gap_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt, w_hold_nxt;
  logic [IDX_W-1:0]   r_idx,      w_idx_nxt;
  logic [N_CH-1:0]    r_rst,      w_rst_nxt;
  logic               r_all_rel,  w_all_rel_nxt;
  logic [CNT_W-1:0]   r_loss_cnt, w_loss_nxt;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_locked),
    .o_q     (w_locked_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_WAIT_LOCK;
      r_filt_cnt <= '0;
      r_gap_cnt  <= '0;
      r_hold_cnt <= '0;
      r_idx      <= '0;
      r_rst      <= '1;
      r_all_rel  <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_filt_cnt <= w_filt_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_idx      <= w_idx_nxt;
      r_rst      <= w_rst_nxt;
      r_all_rel  <= w_all_rel_nxt;
      r_loss_cnt <= w_loss_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_filt_nxt    = r_filt_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_hold_nxt    = r_hold_cnt;
    w_idx_nxt     = r_idx;
    w_rst_nxt     = r_rst;
    w_all_rel_nxt = r_all_rel;
    w_loss_nxt    = r_loss_cnt;

    case (r_state)
      ST_WAIT_LOCK: begin
        w_rst_nxt     = '1;
        w_all_rel_nxt = 1'b0;
        if (w_locked_s) begin
          w_state_nxt = ST_FILTER;
          w_filt_nxt  = '0;
        end
      end

      ST_FILTER: begin
        w_filt_nxt = r_filt_cnt + 1'b1;
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (i_sw_rst) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = '0;
        end else if (r_filt_cnt == FILT_MAX) begin
          w_state_nxt = ST_RELEASE;
          w_gap_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end

      ST_RELEASE, ST_RUN: begin
        // Lock loss wins over software reset so a coincident pair counts once.
        if (!w_locked_s || i_sw_rst) begin
          w_state_nxt   = ST_HOLD;
          w_rst_nxt     = '1;
          w_all_rel_nxt = 1'b0;
          w_hold_nxt    = '0;
          if (!w_locked_s && (r_loss_cnt != '1))
            w_loss_nxt = r_loss_cnt + 1'b1;
        end else if (r_state == ST_RELEASE) begin
          w_gap_nxt = r_gap_cnt + 1'b1;
          if (r_gap_cnt == GAP_MAX) begin
            w_rst_nxt[r_idx] = 1'b0;
            w_gap_nxt        = '0;
            w_idx_nxt        = r_idx + 1'b1;
            if (r_idx == IDX_LAST) begin
              w_state_nxt   = ST_RUN;
              w_all_rel_nxt = 1'b1;
            end
          end
        end
      end

      ST_HOLD: begin
        w_hold_nxt = r_hold_cnt + 1'b1;
        if (r_hold_cnt == HOLD_MAX)
          w_state_nxt = ST_WAIT_LOCK;
      end

      default: begin
        w_state_nxt   = ST_WAIT_LOCK;
        w_rst_nxt     = '1;
        w_all_rel_nxt = 1'b0;
      end
    endcase
  end

  assign o_rst          = r_rst;
  assign o_all_released = r_all_rel;
  assign o_state        = r_state;
  assign o_loss_cnt     = r_loss_cnt;

endmodule

// File: doc/clk_rst_sequencer.md
Name: clk_rst_sequencer

Overview:
- Parametrised successor to the board clock/reset generator's reset logic.
- Consumes the asynchronous PLL/MMCM LOCKED signal and drives N_CH active-high synchronous resets, all in the core clock domain.
- Adds lock filtering, staggered per-channel release, a minimum assert time, a software reset request, and a lock-loss counter.
- Sits between the PLL wrapper and the SoC subsystems (core, bus fabric, peripherals, video).

Parameters:
- N_CH, 3: number of reset outputs, >=1. Released in index order 0..N_CH-1.
- SYNC_STAGES, 2: flop stages synchronising i_locked, >=2.
- LOCK_FILTER, 16: consecutive synchronised-locked cycles required before release begins, >=1.
- RELEASE_GAP, 8: cycles between successive channel releases, >=1.
- MIN_ASSERT, 4: minimum cycles spent in HOLD, >=1.
- CNT_W, 8: width of the lock-loss counter.

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_locked  in  1  PLL LOCKED; asynchronous to i_clk.
- i_sw_rst  in  1  software reset request; synchronous to i_clk, level-sampled every cycle.
- o_rst  out  N_CH  per-channel reset; 1 = held in reset.
- o_all_released  out  1  high while in RUN.
- o_state  out  3  current FSM state encoding.
- o_loss_cnt  out  CNT_W  saturating count of lock losses.

Behaviour:
- Reset (i_rst_n=0, asynchronous, takes effect immediately):
  - o_rst = all ones, o_all_released = 0, o_loss_cnt = 0.
  - State = WAIT_LOCK; sync chain, filter, gap and hold counters, and channel index all cleared.
  - Deassertion of i_rst_n is synchronous to i_clk; the first active edge after it is edge 1.
- locked_s is the last stage of a SYNC_STAGES-deep flop chain on i_locked, reset to 0. All FSM decisions use locked_s only.
- State encodings: WAIT_LOCK=0, FILTER=1, RELEASE=2, RUN=3, HOLD=4.
- WAIT_LOCK:
  - o_rst all ones.
  - locked_s=1 -> FILTER with filt_cnt=0. i_sw_rst is ignored.
- FILTER:
  - filt_cnt increments each cycle.
  - locked_s=0 -> WAIT_LOCK.
  - i_sw_rst=1 -> HOLD.
  - filt_cnt==LOCK_FILTER-1 with locked_s=1 -> RELEASE, gap_cnt=0, idx=0.
- RELEASE:
  - gap_cnt increments each cycle.
  - When gap_cnt==RELEASE_GAP-1: clear o_rst[idx] (registered, visible after that edge), reset gap_cnt, increment idx.
  - Clearing idx==N_CH-1 moves to RUN and sets o_all_released=1 on that same edge.
- RUN:
  - o_rst all zero, o_all_released = 1.
- Exits from RELEASE/RUN (priority order):
  - locked_s=0 -> HOLD; o_loss_cnt increments, saturating at all ones.
  - Otherwise i_sw_rst=1 -> HOLD; o_loss_cnt unchanged.
  - If both occur in the same cycle, treat it as a lock loss (counted).
- Entering HOLD:
  - On the transition edge, o_rst = all ones and o_all_released = 0. Channels already released re-assert.
  - hold_cnt = 0.
- HOLD:
  - Stay until hold_cnt==MIN_ASSERT-1, then -> WAIT_LOCK, regardless of locked_s and i_sw_rst.
  - Lock loss or i_sw_rst while in HOLD is not counted and does not extend HOLD.
- o_rst bits only ever transition 1->0 in index order and 0->1 all together. No glitches: every output is a flop.
- Latency with defaults and i_locked stable high from before edge 1:
  - locked_s high after edge 2; FILTER at edge 3; RELEASE at edge 19.
  - o_rst[0]=0 after edge 27, o_rst[1] after edge 35, o_rst[2] and o_all_released after edge 43.
- Lock-loss latency: o_rst all ones SYNC_STAGES+1 edges after i_locked falls (3 with defaults).
- Counter widths: filt/gap/hold counters use $clog2 of their limit (minimum 1 bit); idx uses $clog2(N_CH) (minimum 1 bit).

Decomposition:
- Package clk_rst_pkg:
  - State localparams/enum: ST_WAIT_LOCK, ST_FILTER, ST_RELEASE, ST_RUN, ST_HOLD.
  - State width constant ST_W=3.
- Sub-module cdc_sync_bit:
  - Parameter STAGES, async active-low reset to 0.
  - Instantiated once for i_locked; reusable elsewhere.

Test Plan:
- Power-up: i_rst_n low for 5 cycles, then high, with i_locked high throughout -> o_rst=3'b111 through edge 26; 3'b110 after edge 27, 3'b100 after 35, 3'b000 and o_all_released=1 after 43; o_state=3.
- Filter abort: i_locked high for 10 cycles, low 1 cycle, high again -> no o_rst bit clears; FILTER restarts from WAIT_LOCK; release timing measured from the second rise.
- Lock loss mid-RELEASE: drop i_locked right after o_rst[0] clears -> o_rst=3'b111 three edges later; o_loss_cnt=1; HOLD for exactly 4 cycles; full sequence replays.
- Software reset in RUN: 1-cycle i_sw_rst -> o_rst=3'b111 next edge, o_loss_cnt unchanged, HOLD 4 cycles, then re-release with filter timing.
- Simultaneous events: i_sw_rst coincident with locked_s falling in RUN -> counted once; with CNT_W=2 and 5 losses, o_loss_cnt saturates at 3.
- Async reset mid-RELEASE: i_rst_n low between clock edges -> o_rst all ones and o_loss_cnt=0 immediately, without waiting for a clock edge.
